// File: rtl/lab3_cache_mem_arbiter_if.sv
// Valid/ready request/response channel pair used between each cache and the
// arbiter, and between the arbiter and the shared memory port.
// The requester side (a cache, or the arbiter toward memory) uses 'master'.
// The responder side (memory, or the arbiter toward each cache) uses 'slave'.
interface lab3_cache_mem_arbiter_if #(
    parameter int REQ_W  = 77,
    parameter int RESP_W = 47
);
    logic              req_val;
    logic              req_rdy;
    logic [REQ_W-1:0]  req_msg;
    logic              resp_val;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp_msg;

    modport master (
        output req_val,
        output req_msg,
        output resp_rdy,
        input  req_rdy,
        input  resp_val,
        input  resp_msg
    );

    modport slave (
        input  req_val,
        input  req_msg,
        input  resp_rdy,
        output req_rdy,
        output resp_val,
        output resp_msg
    );
endinterface

// File: rtl/lab3_cache_mem_arbiter.sv
// Two-port to one-port memory arbiter behind the I/D cache pair.
// The icache (cache0) and dcache (cache1) request streams are merged onto one
// shared memory port. A small ID FIFO records which cache owns each in-flight
// request, so that the in-order memory responses are routed back to the owner.
// Optional build macro LAB3_CACHE_ARB_DPRIO_EN selects fixed dcache priority
// instead of round-robin; the request lock applies in both builds.
module lab3_cache_mem_arbiter #(
    parameter int MAX_OUTST = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    lab3_cache_mem_arbiter_if.slave         cache0,
    lab3_cache_mem_arbiter_if.slave         cache1,
    lab3_cache_mem_arbiter_if.master        mem,
    output logic                            arb_err
);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    logic                 grant;
    logic                 granted_val;
    logic                 lock_q;
    logic                 locked_id_q;
    logic                 rr_last_q;
    logic                 req_val_int;
    logic                 req_fire;
    logic                 resp_fire;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_id;
    logic [MAX_OUTST-1:0] id_mem_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (count_q == '0);
    assign head_id    = id_mem_q[rd_ptr_q];

    // Pick the owner of the shared request port; an unaccepted request keeps its grant.
    always_comb begin
        grant = 1'b0;
        if (lock_q) begin
            grant = locked_id_q;
        end
`ifdef LAB3_CACHE_ARB_DPRIO_EN
        else if (cache1.req_val) begin
            grant = 1'b1;
        end
        else begin
            grant = 1'b0;
        end
`else
        else if (cache0.req_val && cache1.req_val) begin
            grant = ~rr_last_q;
        end
        else if (cache1.req_val) begin
            grant = 1'b1;
        end
        else begin
            grant = 1'b0;
        end
`endif
    end

    // Zero-latency request passthrough, stalled entirely while the ID FIFO is full.
    always_comb begin
        granted_val    = grant ? cache1.req_val : cache0.req_val;
        req_val_int    = !reset && granted_val && !fifo_full;
        req_fire       = req_val_int && mem.req_rdy;
        mem.req_val    = req_val_int;
        mem.req_msg    = grant ? cache1.req_msg : cache0.req_msg;
        cache0.req_rdy = !reset && !grant && mem.req_rdy && !fifo_full;
        cache1.req_rdy = !reset &&  grant && mem.req_rdy && !fifo_full;
    end

    // Route the memory response to the cache recorded at the FIFO head.
    always_comb begin
        cache0.resp_val = !reset && mem.resp_val && !fifo_empty && !head_id;
        cache1.resp_val = !reset && mem.resp_val && !fifo_empty &&  head_id;
        cache0.resp_msg = mem.resp_msg;
        cache1.resp_msg = mem.resp_msg;
        mem.resp_rdy    = !reset && !fifo_empty &&
                          (head_id ? cache1.resp_rdy : cache0.resp_rdy);
        resp_fire       = mem.resp_val && mem.resp_rdy;
    end

    // Hold the grant on a stalled request and remember the last winner for round-robin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q      <= 1'b0;
            locked_id_q <= 1'b0;
            rr_last_q   <= 1'b1;
        end
        else if (req_fire) begin
            lock_q    <= 1'b0;
            rr_last_q <= grant;
        end
        else if (req_val_int) begin
            lock_q      <= 1'b1;
            locked_id_q <= grant;
        end
    end

    // ID FIFO: push the owner on each accepted request, pop on each delivered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_mem_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end
        else begin
            if (req_fire) begin
                id_mem_q[wr_ptr_q] <= grant;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (resp_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({req_fire, resp_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flag for a memory response that no outstanding request can own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_err <= 1'b0;
        end
        else if (mem.resp_val && fifo_empty) begin
            arb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Directed bench for lab3_cache_mem_arbiter with a request/response scoreboard.
module tb_lab3_cache_mem_arbiter;
    localparam int MAX_OUTST = 4;
    localparam int REQ_W     = 77;
    localparam int RESP_W    = 47;

    typedef struct packed {
        logic              port;
        logic [RESP_W-1:0] msg;
    } resp_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic arb_err;

    lab3_cache_mem_arbiter_if #(.REQ_W(REQ_W), .RESP_W(RESP_W)) c0_if ();
    lab3_cache_mem_arbiter_if #(.REQ_W(REQ_W), .RESP_W(RESP_W)) c1_if ();
    lab3_cache_mem_arbiter_if #(.REQ_W(REQ_W), .RESP_W(RESP_W)) mem_if ();

    lab3_cache_mem_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk     (clk),
        .reset   (reset),
        .cache0  (c0_if),
        .cache1  (c1_if),
        .mem     (mem_if),
        .arb_err (arb_err)
    );

    always #5 clk = ~clk;

    logic [REQ_W-1:0]  exp_req_q [$];
    logic              route_q   [$];
    resp_exp_t         exp_resp_q [$];
    int compared   = 0;
    int mismatched = 0;

    logic [REQ_W-1:0]  m_a, m_b, m_p, m_fifth, m_d;
    logic [RESP_W-1:0] r_d;
    logic              g;
    int                i0, i1;

    function automatic logic [REQ_W-1:0] mk_req(input int typ, input int opq, input int addr, input int data);
        return {3'(typ), 8'(opq), 32'(addr), 2'b00, 32'(data)};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(input int typ, input int opq, input int data);
        return {3'(typ), 8'(opq), 2'b00, 2'b00, 32'(data)};
    endfunction

    function automatic logic [REQ_W-1:0] m0(input int i);
        return mk_req(0, 'h20 + i, 'h2000 + i * 4, 0);
    endfunction

    function automatic logic [REQ_W-1:0] m1(input int i);
        return mk_req(1, 'h30 + i, 'h3000 + i * 4, 'h5EED0000 + i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [REQ_W-1:0] q0,
                                 input logic v1, input logic [REQ_W-1:0] q1,
                                 input logic mrdy, input logic rr0, input logic rr1);
        c0_if.req_val   = v0;
        c0_if.req_msg   = q0;
        c1_if.req_val   = v1;
        c1_if.req_msg   = q1;
        mem_if.req_rdy  = mrdy;
        c0_if.resp_rdy  = rr0;
        c1_if.resp_rdy  = rr1;
        mem_if.resp_val = 1'b0;
        mem_if.resp_msg = '0;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic expectReq(input logic port, input logic [REQ_W-1:0] msg);
        exp_req_q.push_back(msg);
        route_q.push_back(port);
    endtask

    task automatic issueResp(input logic [RESP_W-1:0] msg);
        resp_exp_t e;
        if (route_q.size() == 0) begin
            $display("[TB] FAIL issue_resp: observed=no outstanding owner expected=one queued");
            $fatal(1, "[TB] scoreboard underflow");
        end
        e.port = route_q.pop_front();
        e.msg  = msg;
        exp_resp_q.push_back(e);
        mem_if.resp_val = 1'b1;
        mem_if.resp_msg = msg;
    endtask

    task automatic checkMemReq(input string tag);
        logic [REQ_W-1:0] e;
        checkOutput({tag, "_queued"}, 128'(exp_req_q.size() != 0), 128'(1'b1));
        if (exp_req_q.size() != 0) begin
            e = exp_req_q.pop_front();
            checkOutput({tag, "_val"}, 128'(mem_if.req_val), 128'(1'b1));
            checkOutput({tag, "_msg"}, 128'(mem_if.req_msg), 128'(e));
        end
    endtask

    task automatic checkResp(input string tag);
        resp_exp_t e;
        checkOutput({tag, "_queued"}, 128'(exp_resp_q.size() != 0), 128'(1'b1));
        if (exp_resp_q.size() != 0) begin
            e = exp_resp_q.pop_front();
            checkOutput({tag, "_c0_val"}, 128'(c0_if.resp_val), 128'(!e.port));
            checkOutput({tag, "_c1_val"}, 128'(c1_if.resp_val), 128'(e.port));
            checkOutput({tag, "_msg"}, 128'(e.port ? c1_if.resp_msg : c0_if.resp_msg), 128'(e.msg));
            checkOutput({tag, "_mem_rdy"}, 128'(mem_if.resp_rdy), 128'(1'b1));
        end
    endtask

    task automatic doReset();
        tick();
        applyIdle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Linear directed sequence; every expectation comes from the scoreboard queues or constants.
    initial begin
        // Reset with requests and a stray response presented: every val/rdy output stays low.
        applyStimulus(1'b1, mk_req(0, 1, 'h1000, 0), 1'b1, mk_req(1, 2, 'h1004, 7), 1'b1, 1'b1, 1'b1);
        #1;
        reset = 1'b1;
        mem_if.resp_val = 1'b1;
        mem_if.resp_msg = mk_resp(0, 3, 'h1234);
        #2;
        checkOutput("rst_mem_req_val", 128'(mem_if.req_val), 128'(1'b0));
        checkOutput("rst_c0_req_rdy", 128'(c0_if.req_rdy), 128'(1'b0));
        checkOutput("rst_c1_req_rdy", 128'(c1_if.req_rdy), 128'(1'b0));
        checkOutput("rst_mem_resp_rdy", 128'(mem_if.resp_rdy), 128'(1'b0));
        checkOutput("rst_c0_resp_val", 128'(c0_if.resp_val), 128'(1'b0));
        checkOutput("rst_c1_resp_val", 128'(c1_if.resp_val), 128'(1'b0));
        tick();
        tick();
        checkOutput("rst_arb_err", 128'(arb_err), 128'(1'b0));
        applyIdle();
        reset = 1'b0;

        // Single icache read at 0x1000, response data 0xCAFE routed to cache0 only.
        tick();
        m_p = mk_req(0, 'h11, 'h1000, 0);
        applyStimulus(1'b1, m_p, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        expectReq(1'b0, m_p);
        #2;
        checkMemReq("t1_req");
        checkOutput("t1_rdy", 128'({c1_if.req_rdy, c0_if.req_rdy}), 128'(2'b01));
        tick();
        applyIdle();
        issueResp(mk_resp(0, 'h11, 'hCAFE));
        #2;
        checkResp("t1_resp");

        // Both caches streaming with a one-cycle memory: grants and responses alternate.
        doReset();
        i0 = 0;
        i1 = 0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            applyStimulus(k < 6, m0(i0), k < 6, m1(i1), 1'b1, 1'b1, 1'b1);
`ifdef LAB3_CACHE_ARB_DPRIO_EN
            g = 1'b1;
`else
            g = ((k % 2) == 1);
`endif
            if (k < 6) expectReq(g, g ? m1(i1) : m0(i0));
            if (k >= 1) issueResp(mk_resp(0, 'h50 + k, 'hD000 + k));
            #2;
            if (k < 6) begin
                checkMemReq($sformatf("t2_req%0d", k));
                checkOutput($sformatf("t2_rdy%0d", k), 128'({c1_if.req_rdy, c0_if.req_rdy}),
                            128'(g ? 2'b10 : 2'b01));
                if (g) i1++;
                else i0++;
            end
            if (k >= 1) checkResp($sformatf("t2_resp%0d", k));
        end

        // Make cache0 the last winner so an unlocked arbiter would switch to cache1.
        tick();
        m_p = mk_req(0, 'h40, 'h4000, 0);
        applyStimulus(1'b1, m_p, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        expectReq(1'b0, m_p);
        #2;
        checkMemReq("t3_pre");
        tick();
        applyIdle();
        issueResp(mk_resp(0, 'h40, 'h4444));
        #2;
        checkResp("t3_pre_resp");

        // Memory stalls three cycles; cache1 joins in cycle 1 but cache0 keeps the grant.
        m_a = mk_req(1, 'h41, 'h4100, 'h11112222);
        m_b = mk_req(0, 'h42, 'h4200, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            applyStimulus(1'b1, m_a, k >= 1, m_b, 1'b0, 1'b1, 1'b1);
            #2;
            checkOutput($sformatf("t3_lock_val%0d", k), 128'(mem_if.req_val), 128'(1'b1));
            checkOutput($sformatf("t3_lock_msg%0d", k), 128'(mem_if.req_msg), 128'(m_a));
            checkOutput($sformatf("t3_lock_rdy%0d", k), 128'({c1_if.req_rdy, c0_if.req_rdy}), 128'(2'b00));
        end
        tick();
        applyStimulus(1'b1, m_a, 1'b1, m_b, 1'b1, 1'b1, 1'b1);
        expectReq(1'b0, m_a);
        #2;
        checkMemReq("t3_a");
        checkOutput("t3_a_rdy", 128'({c1_if.req_rdy, c0_if.req_rdy}), 128'(2'b01));
        tick();
        applyStimulus(1'b0, '0, 1'b1, m_b, 1'b1, 1'b1, 1'b1);
        expectReq(1'b1, m_b);
        #2;
        checkMemReq("t3_b");
        checkOutput("t3_b_rdy", 128'({c1_if.req_rdy, c0_if.req_rdy}), 128'(2'b10));
        for (int k = 0; k < 2; k++) begin
            tick();
            applyIdle();
            issueResp(mk_resp(0, 'h41 + k, 'hAB00 + k));
            #2;
            checkResp($sformatf("t3_resp%0d", k));
        end

        // Fill the ID FIFO, then the fifth request waits until one response drains.
        for (int k = 0; k < 4; k++) begin
            tick();
            m_p = mk_req(0, 'h60 + k, 'h5000 + k * 4, 0);
            applyStimulus(1'b1, m_p, 1'b0, '0, 1'b1, 1'b1, 1'b1);
            expectReq(1'b0, m_p);
            #2;
            checkMemReq($sformatf("t4_fill%0d", k));
        end
        m_fifth = mk_req(0, 'h55, 'h5500, 0);
        tick();
        applyStimulus(1'b1, m_fifth, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        #2;
        checkOutput("t4_full_rdy", 128'(c0_if.req_rdy), 128'(1'b0));
        checkOutput("t4_full_val", 128'(mem_if.req_val), 128'(1'b0));
        tick();
        applyStimulus(1'b1, m_fifth, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        issueResp(mk_resp(0, 'h60, 'hF000));
        #2;
        checkResp("t4_pop");
        checkOutput("t4_full_pop_rdy", 128'(c0_if.req_rdy), 128'(1'b0));
        checkOutput("t4_full_pop_val", 128'(mem_if.req_val), 128'(1'b0));
        tick();
        applyStimulus(1'b1, m_fifth, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        expectReq(1'b0, m_fifth);
        #2;
        checkMemReq("t4_fifth");
        checkOutput("t4_fifth_rdy", 128'(c0_if.req_rdy), 128'(1'b1));
        for (int k = 1; k <= 4; k++) begin
            tick();
            applyIdle();
            issueResp(mk_resp(0, 'h60 + k, 'hF000 + k));
            #2;
            checkResp($sformatf("t4_drain%0d", k));
        end

        // dcache owns the head but is not ready: the response is held without a pop.
        tick();
        m_d = mk_req(1, 'h70, 'h6000, 'h600D);
        applyStimulus(1'b0, '0, 1'b1, m_d, 1'b1, 1'b1, 1'b1);
        expectReq(1'b1, m_d);
        #2;
        checkMemReq("t5_req");
        r_d = mk_resp(1, 'h70, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
            mem_if.resp_val = 1'b1;
            mem_if.resp_msg = r_d;
            #2;
            checkOutput($sformatf("t5_hold_mem_rdy%0d", k), 128'(mem_if.resp_rdy), 128'(1'b0));
            checkOutput($sformatf("t5_hold_c1_val%0d", k), 128'(c1_if.resp_val), 128'(1'b1));
            checkOutput($sformatf("t5_hold_c0_val%0d", k), 128'(c0_if.resp_val), 128'(1'b0));
            checkOutput($sformatf("t5_hold_msg%0d", k), 128'(c1_if.resp_msg), 128'(r_d));
        end
        tick();
        applyIdle();
        issueResp(r_d);
        #2;
        checkResp("t5_release");

        // Response with nothing outstanding: refused, not routed, and arb_err latches.
        tick();
        applyIdle();
        #2;
        checkOutput("t6_err_before", 128'(arb_err), 128'(1'b0));
        tick();
        applyIdle();
        mem_if.resp_val = 1'b1;
        mem_if.resp_msg = mk_resp(0, 'h77, 'hDEAD);
        #2;
        checkOutput("t6_empty_mem_rdy", 128'(mem_if.resp_rdy), 128'(1'b0));
        checkOutput("t6_empty_c0_val", 128'(c0_if.resp_val), 128'(1'b0));
        checkOutput("t6_empty_c1_val", 128'(c1_if.resp_val), 128'(1'b0));
        checkOutput("t6_err_not_yet", 128'(arb_err), 128'(1'b0));
        tick();
        applyIdle();
        #2;
        checkOutput("t6_err_set", 128'(arb_err), 128'(1'b1));
        tick();
        #2;
        checkOutput("t6_err_sticky", 128'(arb_err), 128'(1'b1));
        doReset();
        #2;
        checkOutput("t6_err_cleared", 128'(arb_err), 128'(1'b0));
        checkOutput("sb_drained", 128'(exp_req_q.size() + exp_resp_q.size() + route_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
